// File: rtl/memory_byte_sequencer_if.sv
// memory_byte_sequencer_if: request, RAM-port and completion signals of the byte sequencer.
`default_nettype none

interface memory_byte_sequencer_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  start;
  logic                  write;
  logic [1:0]            size;
  logic [31:0]           Byte0;
  logic [31:0]           Byte1;
  logic [31:0]           Byte2;
  logic [31:0]           Byte3;
  logic [31:0]           write_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  fault;
  logic [31:0]           read_data;

  modport slave (
    input  start, write, size, Byte0, Byte1, Byte2, Byte3, write_data, mem_rdata,
    output mem_addr, mem_we, mem_wdata, busy, done, fault, read_data
  );

  modport master (
    output start, write, size, Byte0, Byte1, Byte2, Byte3, write_data, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, busy, done, fault, read_data
  );
endinterface

`default_nettype wire

// File: rtl/memory_byte_sequencer.sv
// memory_byte_sequencer: walks 1/2/4 byte lanes over a byte-wide synchronous RAM for load/store.
// Optional FAULT_CHECK_EN rejects sentinel/out-of-range lane addresses without touching the RAM.
`default_nettype none

module memory_byte_sequencer #(
  parameter int ADDR_WIDTH = 13
) (
  input  wire logic               clock,
  input  wire logic               reset,
  memory_byte_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]            r_state;
  logic                  r_write;
  logic [1:0]            r_last;
  logic [1:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr [4];
  logic [31:0]           r_wdata;
  logic [31:0]           r_word;
  logic                  r_cap_valid;
  logic [1:0]            r_cap_lane;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [7:0]            r_mem_wdata;
  logic [31:0]           r_read_data;

  logic [31:0]           w_lane [4];
  logic [1:0]            w_last;
  logic [1:0]            w_next_cnt;
  logic [31:0]           w_word_next;

  assign w_lane[0]  = bus.Byte0;
  assign w_lane[1]  = bus.Byte1;
  assign w_lane[2]  = bus.Byte2;
  assign w_lane[3]  = bus.Byte3;
  assign w_next_cnt = r_cnt + 2'd1;

  // Index of the final lane: size 2 and 3 both mean a full word.
  always_comb begin
    case (bus.size)
      2'd0:    w_last = 2'd0;
      2'd1:    w_last = 2'd1;
      default: w_last = 2'd3;
    endcase
  end

  // RAM data arrives one cycle after its address, so merge it into the lane captured last cycle.
  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_cap_lane, 3'b000} +: 8] = bus.mem_rdata;
  end

`ifdef FAULT_CHECK_EN
  logic r_fault;
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k <= int'(w_last)) begin
        if ((w_lane[k] == 32'hFFFF_FFFF) || (w_lane[k][31:ADDR_WIDTH] != '0)) begin
          w_bad = 1'b1;
        end
      end
    end
  end

  assign bus.fault = r_fault && (r_state == FINISH);
`else
  assign bus.fault = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_last      <= 2'd0;
      r_cnt       <= 2'd0;
      r_wdata     <= '0;
      r_word      <= '0;
      r_cap_valid <= 1'b0;
      r_cap_lane  <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_read_data <= '0;
`ifdef FAULT_CHECK_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      if (r_cap_valid) begin
        r_word <= w_word_next;
      end
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_write     <= bus.write;
            r_last      <= w_last;
            r_wdata     <= bus.write_data;
            r_cnt       <= 2'd0;
            r_word      <= '0;
            r_cap_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
              r_addr[k] <= w_lane[k][ADDR_WIDTH-1:0];
            end
`ifdef FAULT_CHECK_EN
            r_fault <= w_bad;
            if (w_bad) begin
              r_state <= FINISH;
              if (!bus.write) begin
                r_read_data <= 32'hFFFF_FFFF;
              end
            end else
`endif
            begin
              r_mem_addr  <= w_lane[0][ADDR_WIDTH-1:0];
              r_mem_we    <= bus.write;
              r_mem_wdata <= bus.write_data[7:0];
              r_state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          r_cap_valid <= !r_write;
          r_cap_lane  <= r_cnt;
          if (r_cnt == r_last) begin
            r_mem_we <= 1'b0;
            r_state  <= r_write ? FINISH : DRAIN;
          end else begin
            r_cnt       <= w_next_cnt;
            r_mem_addr  <= r_addr[w_next_cnt];
            r_mem_wdata <= r_wdata[{w_next_cnt, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          r_cap_valid <= 1'b0;
          r_read_data <= w_word_next;
          r_state     <= FINISH;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == FINISH);
  assign bus.read_data = r_read_data;

endmodule

`default_nettype wire

// File: tb/tb_memory_byte_sequencer.sv
// tb_memory_byte_sequencer: directed and random load/store transactions against a transaction-level memory model.
`default_nettype none

module tb_memory_byte_sequencer;

  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0]  ram     [1 << AW];
  logic [7:0]  ref_mem [1 << AW];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  memory_byte_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  memory_byte_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  // Byte-wide synchronous RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic scramble();
    bus.write      = 1'($urandom);
    bus.size       = 2'($urandom);
    bus.Byte0      = $urandom;
    bus.Byte1      = $urandom;
    bus.Byte2      = $urandom;
    bus.Byte3      = $urandom;
    bus.write_data = $urandom;
  endtask

  // Called right after a falling edge; returns right after a falling edge with start low.
  task automatic run_txn(input logic wr, input logic [1:0] sz,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3,
                         input logic [31:0] wd, input bit hold);
    logic [31:0] a [4];
    logic [31:0] exp_rd;
    int n, exp_done;
    bit bad;
    a = '{a0, a1, a2, a3};
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad = 1'b0;
`ifdef FAULT_CHECK_EN
    for (int k = 0; k < n; k++)
      if (a[k] == 32'hFFFF_FFFF || a[k][31:AW] != '0) bad = 1'b1;
`endif
    exp_rd = last_rd;
    if (bad) begin
      exp_done = 1;
      if (!wr) exp_rd = 32'hFFFF_FFFF;
    end else if (wr) begin
      exp_done = n + 1;
    end else begin
      exp_done = n + 2;
      exp_rd = 32'h0;
      for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_mem[a[k][AW-1:0]];
    end
    bus.start = 1'b1; bus.write = wr; bus.size = sz;
    bus.Byte0 = a0; bus.Byte1 = a1; bus.Byte2 = a2; bus.Byte3 = a3;
    bus.write_data = wd;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      check((c <= exp_done) ? "busy" : "idle_after", 32'(bus.busy), 32'(c <= exp_done));
      check("done", 32'(bus.done), 32'(c == exp_done));
      if (!bad && c <= n) begin
        check("addr", 32'(bus.mem_addr), 32'(a[c-1][AW-1:0]));
        check("we", 32'(bus.mem_we), 32'(wr));
        if (wr) check("wdata", 32'(bus.mem_wdata), 32'(wd[8*(c-1) +: 8]));
      end else begin
        check("we_idle", 32'(bus.mem_we), 32'h0);
      end
      if (c == exp_done) begin
        check("fault", 32'(bus.fault), 32'(bad));
        check("read_data", bus.read_data, exp_rd);
      end
      scramble();
      bus.start = hold && (c <= exp_done);
    end
    if (wr && !bad)
      for (int k = 0; k < n; k++) ref_mem[a[k][AW-1:0]] = wd[8*k +: 8];
    last_rd = exp_rd;
  endtask

  initial begin
    logic [31:0] wd;
    logic [31:0] ra [4];
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    bus.start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_we", 32'(bus.mem_we), 32'h0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_fault", 32'(bus.fault), 32'h0);
    check("rst_read_data", bus.read_data, 32'h0);
    @(negedge clk);

    run_txn(1'b1, 2'd2, 32'h17FB, 32'h17FA, 32'h17F9, 32'h17F8, 32'hA1B2C3D4, 1'b0);
    run_txn(1'b0, 2'd2, 32'h17FB, 32'h17FA, 32'h17F9, 32'h17F8, 32'h0, 1'b0);
    check("word_load_value", last_rd, 32'hA1B2C3D4);
    run_txn(1'b1, 2'd0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0000007E, 1'b0);
    run_txn(1'b0, 2'd0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("byte_load_value", last_rd, 32'h0000007E);
    run_txn(1'b0, 2'd1, 32'h1001, 32'h1000, 32'h0, 32'h0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd3, 32'h17F8, 32'h17F9, 32'h17FA, 32'h17FB, 32'h0, 1'b1);

    // Reset sampled at the end of cycle 2 of a word store.
    wd = $urandom;
    bus.start = 1'b1; bus.write = 1'b1; bus.size = 2'd2;
    bus.Byte0 = 32'h0100; bus.Byte1 = 32'h0101; bus.Byte2 = 32'h0102; bus.Byte3 = 32'h0103;
    bus.write_data = wd;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_mid_we1", 32'(bus.mem_we), 32'h1);
    @(negedge clk);
    check("rst_mid_we2", 32'(bus.mem_we), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_we3", 32'(bus.mem_we), 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    for (int c = 0; c < 4; c++) begin
      check("rst_mid_no_done", 32'(bus.done), 32'h0);
      @(negedge clk);
    end
    ref_mem[13'h0100] = wd[7:0];
    ref_mem[13'h0101] = wd[15:8];
    last_rd = 32'h0;
    run_txn(1'b0, 2'd0, 32'h0101, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    run_txn(1'b0, 2'd0, 32'h0102, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    run_txn(1'b0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
`ifndef FAULT_CHECK_EN
    check("sentinel_trunc", last_rd, {4{ref_mem[13'h1FFF]}});
`endif

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(32'h0200, 32'h021F));
      run_txn(1'($urandom), 2'($urandom), ra[0], ra[1], ra[2], ra[3], $urandom,
              ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_byte_sequencer.md
# memory_byte_sequencer

Memory-side responder for the four per-lane byte addresses produced by the address handler for push, pop, load and store. It latches a request of one, two or four byte lanes, drives a single-byte synchronous RAM port one lane per cycle, assembles read bytes into a 32-bit word or splits a store word into bytes, and pulses `done` to the control unit. It sits between the address handler/register bank and the byte-wide data RAM.

## Interface
- `ADDR_WIDTH`, 13, RAM address width; lane addresses are truncated to this many LSBs (covers 0x0000–0x1FFF).
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `write`  in  1  1 = store, 0 = load; latched with `start`.
- `size`  in  2  lane count: 0 = 1 byte (lane 0), 1 = 2 bytes (lanes 0–1), 2 or 3 = 4 bytes (lanes 0–3).
- `Byte0`..`Byte3`  in  32 each  lane addresses; lane k carries data bits [8k+7:8k].
- `write_data`  in  32  store word; latched with `start`.
- `mem_addr`  out  ADDR_WIDTH  registered RAM address.
- `mem_we`  out  1  registered RAM write enable.
- `mem_wdata`  out  8  registered RAM write byte.
- `mem_rdata`  in  8  RAM read byte, valid the cycle after `mem_addr` is presented.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  qualifies `done`; only driven when FAULT_CHECK_EN is defined, otherwise tied 0.
- `read_data`  out  32  assembled load word, zero-extended for 1- and 2-byte loads.

## Operation
- States: IDLE, ACCESS, DRAIN, FINISH.
- IDLE: on `start`=1, latch `write`, n = lane count, all four addresses and `write_data`; load `mem_addr`=Byte0[ADDR_WIDTH-1:0], `mem_we`=`write`, `mem_wdata`=write_data[7:0]; lane counter = 0; go to ACCESS.
- ACCESS: one lane per cycle; at each edge the counter increments and the outputs are loaded from the next lane. After lane n-1, `mem_we` clears; a load goes to DRAIN, a store to FINISH.
- Load capture: at the end of each cycle following lane k's presentation, `mem_rdata` goes into bits [8k+7:8k] of an internal word; unused upper lanes are 0.
- DRAIN: one cycle to capture the last lane, then FINISH. `read_data` takes the assembled word at the DRAIN→FINISH edge.
- FINISH: `done`=1 for exactly this cycle, then IDLE.
- `read_data` holds its value until the next load completes; stores never change it.
- `start` is ignored while `busy`=1. No queuing.
- Only `reset` aborts a transaction. On reset: state IDLE, no `done`, and `mem_we`=0 from the next cycle.

## Timing
- Reset values: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `busy`=0, `done`=0, `fault`=0, `read_data`=0.
- Cycle 0 is the cycle in which `start` is sampled. Lane k is on the RAM port in cycle k+1.
- Load of n lanes: `done` in cycle n+2 (byte 3, half 4, word 6).
- Store of n lanes: `done` in cycle n+1 (byte 2, half 3, word 5).
- Earliest back-to-back `start` is the cycle after FINISH.

## Configuration
- `FAULT_CHECK_EN` defined:
  - At `start`, if any used lane address equals 32'hFFFFFFFF (empty-stack sentinel) or has nonzero bits above ADDR_WIDTH-1, skip ACCESS and go directly to FINISH.
  - `done`=1 and `fault`=1 in cycle 1.
  - `mem_we` is never asserted.
  - On a faulted load, `read_data`=32'hFFFFFFFF.
- `FAULT_CHECK_EN` undefined:
  - No check; addresses are truncated and the access proceeds normally.
  - `fault` is constant 0.

## Test plan
- Word store: size=2, Byte0..3 = 0x17FB,0x17FA,0x17F9,0x17F8, write_data=0xA1B2C3D4 -> writes 0xD4,0xC3,0xB2,0xA1 to those addresses in cycles 1–4; `done` in cycle 5.
- Word load of the same addresses with a RAM model -> `read_data`=0xA1B2C3D4 and `done` in cycle 6.
- Byte load: size=0, Byte0=0x1000 holding 0x7E -> `read_data`=0x0000007E, `done` in cycle 3. Half load from 0x1001/0x1000 -> zero-extended 16 bits, `done` in cycle 4.
- `start` held high during a word load -> no second transaction until after FINISH.
- Reset asserted in cycle 2 of a word store -> `mem_we`=0 from cycle 3, no `done`, and a following byte load behaves normally.
- With FAULT_CHECK_EN: word load with all addresses 0xFFFFFFFF -> `done`=`fault`=1 in cycle 1, no RAM access, `read_data`=0xFFFFFFFF. Without FAULT_CHECK_EN: the same stimulus accesses 0x1FFF (truncated) and `fault`=0.
